imem_arb: RTL and testbench

Arbiter sharing the single 128-bit instruction-memory read port between the fetch unit (requester 0) and a second requester (requester 1: debug/literal-pool reads). Requests are granted round-robin, accepted requests are recorded in an in-order tag FIFO, and returning responses are routed back to their originator. Requester 0 can flush its outstanding fetches on a PC redirect, so stale lines are dropped rather than delivered.

---
 rtl/anom_ifu_pkg.sv | 15 +
 rtl/imem_tag_fifo.sv | 68 ++++++
 rtl/imem_arb.sv | 93 +++++++++
 tb/tb_imem_arb.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/anom_ifu_pkg.sv
// Shared instruction-fetch definitions: PC width, line width and requester tags.
package anom_ifu_pkg;
    localparam int ANOM_PC_WIDTH = 30;
    localparam int LINE_W = 128;

    typedef enum logic {
        TAG_IFU = 1'b0,
        TAG_AUX = 1'b1
    } tag_e;

    typedef struct packed {
        logic tag;
        logic kill;
    } tag_ent_t;
endpackage

// File: rtl/imem_tag_fifo.sv
// In-order {tag, kill} FIFO tracking outstanding memory reads; supports
// marking every fetch-unit entry as killed in a single cycle.
module imem_tag_fifo
    import anom_ifu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             push_tag,
    input  logic             pop,
    input  logic             kill_ifu,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             head_tag,
    output logic             head_kill
);
    tag_ent_t         ent_q [DEPTH];
    tag_ent_t         ent_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign count     = cnt_q;
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_tag  = ent_q[rd_ptr_q].tag;
    assign head_kill = ent_q[rd_ptr_q].kill;

    always_comb begin
        ent_d    = ent_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (kill_ifu) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_q[i].tag == TAG_IFU) ent_d[i].kill = 1'b1;
            end
        end
        // A push in the kill cycle is newer than the redirect, so it lands unkilled.
        if (do_push) begin
            ent_d[wr_ptr_q] = '{tag: push_tag, kill: 1'b0};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            ent_q    <= ent_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/imem_arb.sv
// Round-robin arbiter for the shared instruction-memory read port, with
// in-order response routing and fetch-flush support.
module imem_arb
    import anom_ifu_pkg::*;
#(
    parameter int PC_WIDTH = ANOM_PC_WIDTH,
    parameter int DEPTH    = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Req0V,
    input  logic [PC_WIDTH-3:0] i_Req0A,
    input  logic              i_Req1V,
    input  logic [PC_WIDTH-3:0] i_Req1A,
    output logic              o_Req0R,
    output logic              o_Req1R,
    input  logic              i_Flush0,
    output logic              o_MemV,
    output logic [PC_WIDTH-3:0] o_MemA,
    input  logic              i_MemR,
    input  logic              i_RspV,
    input  logic [LINE_W-1:0] i_RspD,
    output logic              o_Rsp0V,
    output logic              o_Rsp1V,
    output logic [LINE_W-1:0] o_RspD,
    output logic              o_Err
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              fifo_full, fifo_empty, head_tag, head_kill;
    logic [CNT_W-1:0]  fifo_count;
    logic              last_q, last_d;
    logic              rsp0_v_q, rsp0_v_d, rsp1_v_q, rsp1_v_d;
    logic              err_q, err_d;
    logic [LINE_W-1:0] rsp_data_q, rsp_data_d;
    logic              elig0, elig1, gnt1, accept, pop, drop, deliver;

    imem_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (i_Clk),
        .rst      (i_Rst),
        .push     (accept),
        .push_tag (gnt1),
        .pop      (pop),
        .kill_ifu (i_Flush0),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .head_tag (head_tag),
        .head_kill(head_kill)
    );

    always_comb begin
        elig0   = i_Req0V & ~fifo_full;
        elig1   = i_Req1V & ~fifo_full;
        gnt1    = elig1 & (~elig0 | (last_q == TAG_IFU));
        o_MemV  = elig0 | elig1;
        o_MemA  = gnt1 ? i_Req1A : i_Req0A;
        accept  = o_MemV & i_MemR;
        o_Req0R = accept & ~gnt1;
        o_Req1R = accept & gnt1;
        last_d  = accept ? gnt1 : last_q;

        // A fetch head leaving in the flush cycle is stale even though its kill bit is not yet set.
        pop        = i_RspV & ~fifo_empty;
        drop       = head_kill | (i_Flush0 & (head_tag == TAG_IFU));
        deliver    = pop & ~drop;
        rsp0_v_d   = deliver & (head_tag == TAG_IFU);
        rsp1_v_d   = deliver & (head_tag == TAG_AUX);
        rsp_data_d = deliver ? i_RspD : rsp_data_q;
        err_d      = err_q | (i_RspV & (fifo_count == '0));
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            last_q     <= TAG_AUX;
            rsp0_v_q   <= 1'b0;
            rsp1_v_q   <= 1'b0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            last_q     <= last_d;
            rsp0_v_q   <= rsp0_v_d;
            rsp1_v_q   <= rsp1_v_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
        end
    end

    assign o_Rsp0V = rsp0_v_q;
    assign o_Rsp1V = rsp1_v_q;
    assign o_RspD  = rsp_data_q;
    assign o_Err   = err_q;
endmodule

// File: tb/tb_imem_arb.sv
// Bench for imem_arb: table vectors plus hand sequences, checked against a
// queue-based reference model and a response scoreboard.
module tb_imem_arb;
    import anom_ifu_pkg::*;

    localparam int PCW   = 30;
    localparam int AW    = PCW - 2;
    localparam int DEPTH = 4;

    logic           i_Clk = 1'b0;
    logic           i_Rst = 1'b1;
    logic           i_Req0V = 1'b0, i_Req1V = 1'b0;
    logic [AW-1:0]  i_Req0A = '0, i_Req1A = '0;
    logic           o_Req0R, o_Req1R;
    logic           i_Flush0 = 1'b0;
    logic           o_MemV;
    logic [AW-1:0]  o_MemA;
    logic           i_MemR = 1'b0;
    logic           i_RspV = 1'b0;
    logic [127:0]   i_RspD = '0;
    logic           o_Rsp0V, o_Rsp1V;
    logic [127:0]   o_RspD;
    logic           o_Err;

    imem_arb #(.PC_WIDTH(PCW), .DEPTH(DEPTH)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst),
        .i_Req0V(i_Req0V), .i_Req0A(i_Req0A), .i_Req1V(i_Req1V), .i_Req1A(i_Req1A),
        .o_Req0R(o_Req0R), .o_Req1R(o_Req1R), .i_Flush0(i_Flush0),
        .o_MemV(o_MemV), .o_MemA(o_MemA), .i_MemR(i_MemR),
        .i_RspV(i_RspV), .i_RspD(i_RspD),
        .o_Rsp0V(o_Rsp0V), .o_Rsp1V(o_Rsp1V), .o_RspD(o_RspD), .o_Err(o_Err)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct { logic tag; logic kill; } ment_t;
    typedef struct { logic v0; logic v1; logic [127:0] d; } exp_t;
    typedef struct {
        logic r0v; logic r1v; logic [AW-1:0] a0; logic [AW-1:0] a1;
        logic rspv; logic [127:0] d; logic x0r; logic x1r;
    } vec_t;

    ment_t m_q[$];
    exp_t  sb[$];
    logic  m_last = 1'b1;
    logic  m_err  = 1'b0;
    int    n_vec  = 0;
    int    n_bad  = 0;
    vec_t  tbl [8];
    logic  s0, s1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check request path, update model, check registered outputs.
    task automatic cycle(input logic r0v, input logic [AW-1:0] a0, input logic r1v,
                         input logic [AW-1:0] a1, input logic memr, input logic rspv,
                         input logic [127:0] d, input logic fl,
                         output logic q0r, output logic q1r);
        logic  full, e0, e1, g1, memv, acc;
        exp_t  e;
        ment_t h;
        i_Req0V = r0v; i_Req0A = a0; i_Req1V = r1v; i_Req1A = a1;
        i_MemR = memr; i_RspV = rspv; i_RspD = d; i_Flush0 = fl;
        #1;
        q0r  = o_Req0R;
        q1r  = o_Req1R;
        full = (m_q.size() == DEPTH);
        e0   = r0v & ~full;
        e1   = r1v & ~full;
        g1   = e1 & (~e0 | ~m_last);
        memv = e0 | e1;
        acc  = memv & memr;
        chk("mem_v", o_MemV, memv);
        if (memv) chk("mem_a", o_MemA, g1 ? a1 : a0);
        chk("req0_r", o_Req0R, acc & ~g1);
        chk("req1_r", o_Req1R, acc & g1);
        e = '{1'b0, 1'b0, 128'h0};
        if (rspv) begin
            if (m_q.size() == 0) m_err = 1'b1;
            else begin
                h = m_q.pop_front();
                if (!h.kill && !(fl && h.tag == 1'b0)) begin
                    e.v0 = ~h.tag; e.v1 = h.tag; e.d = d;
                end
            end
        end
        sb.push_back(e);
        if (fl) foreach (m_q[i]) if (m_q[i].tag == 1'b0) m_q[i].kill = 1'b1;
        if (acc) begin
            m_q.push_back('{g1, 1'b0});
            m_last = g1;
        end
        @(posedge i_Clk);
        #1;
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
            e = sb.pop_front();
            chk("rsp0_v", o_Rsp0V, e.v0);
            chk("rsp1_v", o_Rsp1V, e.v1);
            if (e.v0 | e.v1) chk("rsp_d", o_RspD, e.d);
        end
        chk("err", o_Err, m_err);
        @(negedge i_Clk);
    endtask

    task automatic idle_in();
        i_Req0V = 0; i_Req1V = 0; i_MemR = 0; i_RspV = 0; i_Flush0 = 0; i_RspD = '0;
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        idle_in();
        #2;
        i_Rst = 1'b1;
        #1;
        chk("rst_mem_v", o_MemV, 0);
        chk("rst_req0_r", o_Req0R, 0);
        chk("rst_req1_r", o_Req1R, 0);
        chk("rst_rsp0_v", o_Rsp0V, 0);
        chk("rst_rsp1_v", o_Rsp1V, 0);
        chk("rst_rsp_d", o_RspD, 0);
        chk("rst_err", o_Err, 0);
        m_q.delete(); sb.delete(); m_last = 1'b1; m_err = 1'b0;
        @(posedge i_Clk);
        @(negedge i_Clk);
        i_Rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b1, 28'h200, 28'h300, 1'b0, 128'h0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 28'h201, 28'h301, 1'b0, 128'h0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 28'h202, 28'h302, 1'b0, 128'h0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 28'h203, 28'h303, 1'b0, 128'h0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 28'h0, 28'h0, 1'b1, {4{32'h1111_0000}}, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 28'h0, 28'h0, 1'b1, {4{32'h2222_0001}}, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 28'h0, 28'h0, 1'b1, {4{32'h3333_0002}}, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 28'h0, 28'h0, 1'b1, {4{32'h4444_0003}}, 1'b0, 1'b0};

        @(negedge i_Clk);
        do_reset();

        // Idle, then a single fetch with its response two cycles later.
        cycle(0, 0, 0, 0, 0, 0, 0, 0, s0, s1);
        cycle(1, 28'h100, 0, 0, 1, 0, 0, 0, s0, s1);
        chk("first_req0_r", s0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, s0, s1);
        cycle(0, 0, 0, 0, 0, 1, {16{8'hA5}}, 0, s0, s1);
        chk("first_rsp0_v", o_Rsp0V, 1);
        chk("first_rsp_d", o_RspD, {16{8'hA5}});
        cycle(0, 0, 0, 0, 0, 0, 0, 0, s0, s1);
        chk("rsp0_pulse_single", o_Rsp0V, 0);

        // Round-robin grants and in-order routing from a fresh reset.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].r0v, tbl[i].a0, tbl[i].r1v, tbl[i].a1, 1'b1, tbl[i].rspv,
                  tbl[i].d, 1'b0, s0, s1);
            chk("tbl_req0_r", s0, tbl[i].x0r);
            chk("tbl_req1_r", s1, tbl[i].x1r);
        end

        // Fill to DEPTH, stall, pop while full (no slot freed), then resume.
        for (int i = 0; i < DEPTH; i++) cycle(1, 28'h400 + AW'(i), 1, 28'h500 + AW'(i), 1, 0, 0, 0, s0, s1);
        cycle(1, 28'h410, 1, 28'h510, 1, 0, 0, 0, s0, s1);
        chk("full_req0_r", s0, 0);
        chk("full_req1_r", s1, 0);
        chk("full_mem_v", o_MemV, 0);
        cycle(1, 28'h411, 1, 28'h511, 1, 1, {2{64'hF0F0_0000_0000_0001}}, 0, s0, s1);
        chk("full_pop_req_r", s0 | s1, 0);
        cycle(1, 28'h412, 1, 28'h512, 1, 0, 0, 0, s0, s1);
        chk("resume_accept", s0 | s1, 1);
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 0, 0, 1, 128'(i + 32'h77), 0, s0, s1);

        // Flush with FIFO holding {0,1,0} while a new fetch is accepted.
        cycle(1, 28'h10, 0, 0, 1, 0, 0, 0, s0, s1);
        cycle(0, 0, 1, 28'h11, 1, 0, 0, 0, s0, s1);
        cycle(1, 28'h12, 0, 0, 1, 0, 0, 0, s0, s1);
        cycle(1, 28'h13, 0, 0, 1, 0, 0, 1, s0, s1);
        chk("flush_cycle_req0_r", s0, 1);
        cycle(0, 0, 0, 0, 0, 1, 128'hD1, 0, s0, s1);
        chk("flush_old0_dropped", o_Rsp0V, 0);
        cycle(0, 0, 0, 0, 0, 1, 128'hD2, 0, s0, s1);
        chk("flush_tag1_kept", o_Rsp1V, 1);
        cycle(0, 0, 0, 0, 0, 1, 128'hD3, 0, s0, s1);
        cycle(0, 0, 0, 0, 0, 1, 128'hD4, 0, s0, s1);
        chk("flush_new0_kept", o_Rsp0V, 1);
        // Fetch head popped in the flush cycle itself is dropped.
        cycle(1, 28'h20, 0, 0, 1, 0, 0, 0, s0, s1);
        cycle(0, 0, 0, 0, 0, 1, 128'hE1, 1, s0, s1);
        chk("flush_pop_dropped", o_Rsp0V, 0);

        // Orphan response sets a sticky error.
        cycle(0, 0, 0, 0, 0, 1, 128'hBAD, 0, s0, s1);
        chk("err_set", o_Err, 1);
        cycle(0, 0, 1, 28'h30, 1, 0, 0, 0, s0, s1);
        cycle(0, 0, 0, 0, 0, 1, 128'hC1, 0, s0, s1);
        chk("err_sticky", o_Err, 1);

        // Reset with three outstanding requests and a response pulse in flight.
        cycle(1, 28'h40, 1, 28'h41, 1, 0, 0, 0, s0, s1);
        cycle(1, 28'h42, 1, 28'h43, 1, 0, 0, 0, s0, s1);
        cycle(1, 28'h44, 1, 28'h45, 1, 0, 0, 0, s0, s1);
        cycle(0, 0, 0, 0, 0, 1, 128'hCAFE, 0, s0, s1);
        chk("pre_rst_rsp0_v", o_Rsp0V, 1);
        do_reset();
        cycle(1, 28'h50, 1, 28'h51, 1, 0, 0, 0, s0, s1);
        chk("post_rst_tie_req0", s0, 1);
        cycle(0, 0, 0, 0, 0, 1, 128'h55, 0, s0, s1);
        cycle(0, 0, 0, 0, 0, 1, 128'h66, 0, s0, s1);
        chk("post_rst_orphan_err", o_Err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
